riscv_muldiv_unit: RTL and testbench
====================================

Name: riscv_muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit, directly downstream of the operand-A/operand-B select muxes.
- Consumes opr_a/opr_b when the decoded instruction is an M-extension op.
- Holds the core through a start/busy/done handshake; the controller stalls the PC and register-file write while busy=1.
- One radix-2 shift-add/restoring-subtract datapath is shared by all eight M ops.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 6, iteration counter width (must satisfy 2^CNT_W > XLEN).

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new operation; sampled only when accepting (IDLE or DONE).
- flush  input  1  abort in-flight operation (pipeline redirect/trap).
- funct3  input  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- opr_a  input  XLEN  operand A (rs1 path from operand-A mux).
- opr_b  input  XLEN  operand B (rs2 path).
- busy  output  1  operation in progress; the controller must stall.
- done  output  1  one-cycle pulse; result valid this cycle.
- result  output  XLEN  final result; holds its value until the next done.

Behaviour:
- Reset (rst_n=0, async): state=IDLE; busy=0, done=0, result=0; counter and internal registers cleared.
- States:
  - IDLE: waiting for start.
  - CALC: one iteration per cycle.
  - DONE: sign fixup applied, done=1.
- Accept:
  - start=1 in IDLE or DONE latches opr_a, opr_b and funct3; later input changes are ignored.
  - start while in CALC is ignored.
- Signed ops:
  - Latch operand magnitudes and result-sign flags.
  - MULH: both operands signed.
  - MULHSU: A signed, B unsigned.
  - DIV/REM: both operands signed. Quotient sign = sA^sB; remainder sign = sA.
- Special cases (divide ops only), checked at accept:
  - opr_b==0: quotient=all ones, remainder=opr_a.
  - Signed overflow (A=0x80000000, B=0xFFFFFFFF): quotient=0x80000000, remainder=0.
  - Both go IDLE/DONE -> DONE directly; done asserts the cycle after the start edge (latency 1).
- Normal latency:
  - Start sampled at edge N: CALC for XLEN cycles, counter loaded with XLEN and decremented each cycle.
  - Counter==1 in CALC -> DONE. done=1 during cycle N+XLEN+1.
- Multiply: unsigned shift-add into a 2*XLEN accumulator.
  - MUL returns the low XLEN bits.
  - MULH* return the high XLEN bits after 2*XLEN-bit negation when the sign flag is set.
- Divide: restoring division, remainder width XLEN+1, one quotient bit per cycle, MSB first. Negation applied in DONE.
- busy=1 in CALC and in the accept cycle; busy=0 in IDLE and DONE.
- DONE -> IDLE if start=0; DONE -> CALC (or DONE for a special case) if start=1, giving back-to-back operation.
- result register updates only on entry to DONE.
- flush=1 in any state -> IDLE next edge; done suppressed; result unchanged. flush has priority over start in the same cycle.
- rst_n deasserting mid-CALC aborts immediately; no done is produced.

Decomposition:
- Shared package riscv_m_pkg:
  - typedef enum logic[2:0] m_op_e (the 8 funct3 codes).
  - typedef enum logic[1:0] muldiv_state_e {IDLE, CALC, DONE}.
  - Constants DIV0_QUOT='1 and INT_MIN=32'h8000_0000.
- One sub-module is natural: riscv_muldiv_signfix, combinational magnitude extraction and conditional negation, instantiated at input and output.
- FSM, counter and datapath stay in riscv_muldiv_unit.

Test Plan:
- MUL 7 x -3 (0x00000007, 0xFFFFFFFD) -> done at cycle N+33, result=0xFFFFFFEB; busy high exactly 33 cycles.
- MULH/MULHSU/MULHU with A=0xFFFFFFFF, B=0xFFFFFFFF:
  - MULH -> 0x00000000.
  - MULHSU -> 0xFFFFFFFF.
  - MULHU -> 0xFFFFFFFE.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC.
- Divide by zero and signed overflow, each done at N+1:
  - DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000/-1 -> 0x80000000; REM of the same -> 0.
- Back-to-back and ignored start:
  - start held during DONE -> second op accepted with no IDLE cycle.
  - start pulsed mid-CALC -> ignored; first result correct.
- flush at CALC cycle 10 -> IDLE, no done, result keeps its prior value. rst_n low mid-CALC -> all outputs 0 immediately.

Source files
------------

// File: rtl/riscv_m_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package riscv_m_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } m_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

    localparam logic [31:0] DIV0_QUOT = '1;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;

endpackage

// File: rtl/riscv_muldiv_signfix.sv
// Conditional two's-complement negation: magnitude extraction on the way in,
// sign restoration on the way out.
module riscv_muldiv_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);

    assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M unit: one radix-2 shift-add / restoring-subtract step per cycle,
// shared by all eight M ops, with a start/busy/done handshake toward the core.
module riscv_muldiv_unit
    import riscv_m_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] opr_a,
    input  logic [XLEN-1:0] opr_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    muldiv_state_e     state_q;
    m_op_e             op_q;
    logic              neg_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   opd_q;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   result_q;

    m_op_e           op_in;
    logic            sgn_a_in, sgn_b_in, neg_in, accept;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] mag_a, mag_b, special_res;

    assign op_in    = m_op_e'(funct3);
    assign sgn_a_in = opr_a[XLEN-1] & (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    assign sgn_b_in = opr_b[XLEN-1] & (op_in inside {OP_MULH, OP_DIV, OP_REM});
    assign neg_in   = (op_in == OP_REM) ? sgn_a_in :
                      (op_in inside {OP_MULH, OP_MULHSU, OP_DIV}) ? (sgn_a_in ^ sgn_b_in) : 1'b0;

    riscv_muldiv_signfix #(.W(XLEN)) u_fix_a (.val_i(opr_a), .neg_i(sgn_a_in), .val_o(mag_a));
    riscv_muldiv_signfix #(.W(XLEN)) u_fix_b (.val_i(opr_b), .neg_i(sgn_b_in), .val_o(mag_b));

    // Divide special cases bypass the iteration and land in DONE one edge after accept.
    assign div_zero    = funct3[2] && (opr_b == '0);
    assign div_ovf     = (op_in inside {OP_DIV, OP_REM}) && (opr_a == INT_MIN) && (opr_b == '1);
    assign special_res = div_zero ? (funct3[1] ? opr_a : DIV0_QUOT)
                                  : (funct3[1] ? '0 : INT_MIN);

    assign accept = (state_q == IDLE || state_q == DONE) && start && !flush;
    assign busy   = (state_q == CALC) || accept;
    assign done   = (state_q == DONE);
    assign result = result_q;

    // acc_q holds {partial product, multiplier} for MUL*, {remainder, dividend/quotient} for DIV*.
    logic [XLEN:0] mul_sum, div_trial, div_diff;
    logic          q_bit;

    assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    assign div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_diff  = div_trial - {1'b0, opd_q};
    assign q_bit     = ~div_diff[XLEN];
    assign acc_d     = op_q[2] ? {(q_bit ? div_diff[XLEN-1:0] : div_trial[XLEN-1:0]),
                                  acc_q[XLEN-2:0], q_bit}
                               : {mul_sum, acc_q[XLEN-1:1]};

    logic [2*XLEN-1:0] fix_in, fix_out;
    logic [XLEN-1:0]   final_res;

    assign fix_in = op_q[2] ? {{XLEN{1'b0}}, (op_q[1] ? acc_d[2*XLEN-1:XLEN] : acc_d[XLEN-1:0])}
                            : acc_d;

    riscv_muldiv_signfix #(.W(2*XLEN)) u_fix_res (.val_i(fix_in), .neg_i(neg_q), .val_o(fix_out));

    assign final_res = (op_q == OP_MUL || op_q[2]) ? fix_out[XLEN-1:0] : fix_out[2*XLEN-1:XLEN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= OP_MUL;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            opd_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else if (flush) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        op_q  <= op_in;
                        neg_q <= neg_in;
                        if (div_zero || div_ovf) begin
                            state_q  <= DONE;
                            result_q <= special_res;
                        end else begin
                            state_q <= CALC;
                            cnt_q   <= CNT_W'(XLEN);
                            opd_q   <= funct3[2] ? mag_b : mag_a;
                            acc_q   <= {{XLEN{1'b0}}, (funct3[2] ? mag_a : mag_b)};
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q  <= DONE;
                        result_q <= final_res;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Directed bench for riscv_muldiv_unit: hand-computed results, latencies and
// handshake behaviour (back-to-back, ignored start, flush, async reset).
module tb_riscv_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] opr_a = '0;
    logic [31:0] opr_b = '0;
    logic        busy, done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_start = 0;
    int busy_cnt = 0;

    riscv_muldiv_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .funct3(funct3),
        .opr_a(opr_a), .opr_b(opr_b), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs are driven at posedge+1 and sampled at posedge+2 / posedge+1.
    task automatic step();
        #1;
        busy_cnt += int'(busy);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic launch(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
        t_start  = cyc;
        busy_cnt = 0;
        funct3 = fn;
        opr_a  = a;
        opr_b  = b;
        start  = 1'b1;
        step();
        start  = 1'b0;
        opr_a  = $urandom;
        opr_b  = $urandom;
        funct3 = 3'($urandom_range(0, 7));
    endtask

    task automatic wait_done(input logic [31:0] exp_res, input int exp_lat, input string tag);
        while (done !== 1'b1 && (cyc - t_start) < 100) step();
        check({tag, "_done"}, 64'(done), 64'(1));
        check({tag, "_lat"}, 64'(cyc - t_start), 64'(exp_lat));
        check({tag, "_res"}, 64'(result), 64'(exp_res));
        check({tag, "_busycyc"}, 64'(busy_cnt), 64'(exp_lat));
    endtask

    initial begin
        int dones;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_result", 64'(result), 64'(0));
        rst_n = 1'b1;
        step();

        launch(3'b000, 32'h0000_0007, 32'hFFFF_FFFD);
        wait_done(32'hFFFF_FFEB, 33, "mul");
        check("mul_done_busy", 64'(busy), 64'(0));
        step();
        check("mul_after_done", 64'(done), 64'(0));
        check("mul_hold", 64'(result), 64'hFFFF_FFEB);

        launch(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(32'h0000_0000, 33, "mulh");
        step();
        launch(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(32'hFFFF_FFFF, 33, "mulhsu");
        step();
        launch(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(32'hFFFF_FFFE, 33, "mulhu");
        step();

        launch(3'b100, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_done(32'hFFFF_FFFD, 33, "div");
        step();
        launch(3'b110, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_done(32'hFFFF_FFFF, 33, "rem");
        step();
        launch(3'b101, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_done(32'h7FFF_FFFC, 33, "divu");
        step();

        launch(3'b100, 32'd5, 32'd0);
        wait_done(32'hFFFF_FFFF, 1, "div0");
        step();
        launch(3'b111, 32'd5, 32'd0);
        wait_done(32'd5, 1, "remu0");
        step();
        launch(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(32'h8000_0000, 1, "div_ovf");
        step();
        launch(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(32'h0000_0000, 1, "rem_ovf");
        step();

        // Back-to-back: each launch below happens while the previous op is in DONE.
        launch(3'b101, 32'd100, 32'd7);
        wait_done(32'd14, 33, "b2b_first");
        launch(3'b110, 32'd100, 32'd7);
        wait_done(32'd2, 33, "b2b_second");
        launch(3'b100, 32'd1, 32'd0);
        wait_done(32'hFFFF_FFFF, 1, "b2b_special");
        step();
        check("b2b_to_idle", 64'(done), 64'(0));

        launch(3'b011, 32'h0001_0000, 32'h0001_0000);
        repeat (5) step();
        funct3 = 3'b100;
        opr_a  = 32'd9;
        opr_b  = 32'd0;
        start  = 1'b1;
        step();
        start  = 1'b0;
        wait_done(32'h0000_0001, 33, "ign_start");
        step();

        launch(3'b000, 32'd3, 32'd5);
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'(0));
        check("flush_done", 64'(done), 64'(0));
        check("flush_result", 64'(result), 64'h0000_0001);
        dones = 0;
        repeat (40) begin
            step();
            dones += int'(done);
        end
        check("flush_no_done", 64'(dones), 64'(0));

        funct3 = 3'b100;
        opr_a  = 32'd5;
        opr_b  = 32'd0;
        start  = 1'b1;
        flush  = 1'b1;
        step();
        start  = 1'b0;
        flush  = 1'b0;
        check("flush_prio_done", 64'(done), 64'(0));
        check("flush_prio_busy", 64'(busy), 64'(0));

        launch(3'b000, 32'd3, 32'd5);
        repeat (10) step();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_result", 64'(result), 64'(0));
        step();
        rst_n = 1'b1;
        step();
        check("midrst_after_done", 64'(done), 64'(0));

        launch(3'b000, 32'd3, 32'd5);
        wait_done(32'd15, 33, "post_rst_mul");
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
